// File: rtl/rm_gmem_rsp_pkg.sv
// Shared types and constants for the gmem AXI4 memory responder.
package rm_gmem_rsp_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int BEAT_BYTES = 16;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // WRAP and the reserved encoding both walk the address like INCR.
  function automatic logic burst_advances(input logic [1:0] burst);
    case (burst)
      BURST_FIXED:            return 1'b0;
      BURST_INCR, BURST_WRAP: return 1'b1;
      default:                return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/rm_gmem_rsp_ram.sv
// Simple dual-port RAM, 128-bit words: byte-enabled write port, registered
// read-first read port whose output register resets to zero.
module rm_gmem_rsp_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [127:0]          wdata_i,
  input  logic [15:0]           wbe_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [127:0]          rdata_o
);

  logic [127:0] mem_q [2**DEPTH_LOG2];
  logic [127:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 16; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Same-cycle write to the read word returns the old contents (NBA ordering).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rm_gmem_responder.sv
// AXI4 slave terminating the RM gmem master port on an on-chip RAM.
// Optional RM_GMEM_RSP_RANGE_CHK_EN: out-of-range bursts are suppressed with SLVERR.
module rm_gmem_responder
  import rm_gmem_rsp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int ID_W       = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            s_axi_gmem_awvalid,
  output logic            s_axi_gmem_awready,
  input  logic [48:0]     s_axi_gmem_awaddr,
  input  logic [ID_W-1:0] s_axi_gmem_awid,
  input  logic [7:0]      s_axi_gmem_awlen,
  input  logic [1:0]      s_axi_gmem_awburst,
  input  logic [2:0]      s_axi_gmem_awsize,
  input  logic [1:0]      s_axi_gmem_awlock,
  input  logic [3:0]      s_axi_gmem_awcache,
  input  logic [2:0]      s_axi_gmem_awprot,
  input  logic [3:0]      s_axi_gmem_awqos,
  input  logic [3:0]      s_axi_gmem_awregion,
  input  logic            s_axi_gmem_wvalid,
  output logic            s_axi_gmem_wready,
  input  logic [127:0]    s_axi_gmem_wdata,
  input  logic [15:0]     s_axi_gmem_wstrb,
  input  logic            s_axi_gmem_wlast,
  output logic            s_axi_gmem_bvalid,
  input  logic            s_axi_gmem_bready,
  output logic [1:0]      s_axi_gmem_bresp,
  output logic [ID_W-1:0] s_axi_gmem_bid,
  input  logic            s_axi_gmem_arvalid,
  output logic            s_axi_gmem_arready,
  input  logic [48:0]     s_axi_gmem_araddr,
  input  logic [ID_W-1:0] s_axi_gmem_arid,
  input  logic [7:0]      s_axi_gmem_arlen,
  input  logic [1:0]      s_axi_gmem_arburst,
  input  logic [2:0]      s_axi_gmem_arsize,
  input  logic [1:0]      s_axi_gmem_arlock,
  input  logic [3:0]      s_axi_gmem_arcache,
  input  logic [2:0]      s_axi_gmem_arprot,
  input  logic [3:0]      s_axi_gmem_arqos,
  input  logic [3:0]      s_axi_gmem_arregion,
  output logic            s_axi_gmem_rvalid,
  input  logic            s_axi_gmem_rready,
  output logic [127:0]    s_axi_gmem_rdata,
  output logic            s_axi_gmem_rlast,
  output logic [ID_W-1:0] s_axi_gmem_rid,
  output logic [1:0]      s_axi_gmem_rresp,
  output w_state_e        dbg_w_state_o,
  output r_state_e        dbg_r_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  localparam int OFF_W = $clog2(BEAT_BYTES);
  localparam int AW    = DEPTH_LOG2;
`ifdef RM_GMEM_RSP_RANGE_CHK_EN
  localparam logic RANGE_CHK = 1'b1;
`else
  localparam logic RANGE_CHK = 1'b0;
`endif

  w_state_e        w_state_q;
  logic [AW-1:0]   w_addr_q;
  logic [7:0]      w_len_q, w_cnt_q;
  logic            w_adv_q, w_err_q, w_oor_q;
  logic            awready_q, wready_q, bvalid_q;
  logic [1:0]      bresp_q;
  logic [ID_W-1:0] bid_q;
  logic            w_beat, w_final, w_sup, w_err_d;

  r_state_e        r_state_q;
  logic [AW-1:0]   r_addr_q;
  logic [7:0]      r_len_q, r_cnt_q;
  logic            r_adv_q, r_oor_q;
  logic            arready_q, rvalid_q, rlast_q;
  logic [1:0]      rresp_q;
  logic [ID_W-1:0] rid_q;
  logic            r_beat, r_sup, ram_re;
  logic [127:0]    ram_rdata;

  assign w_beat  = s_axi_gmem_wvalid && wready_q;
  assign w_final = (w_cnt_q == w_len_q);
  assign w_sup   = RANGE_CHK & w_oor_q;
  assign w_err_d = w_err_q | (s_axi_gmem_wlast != w_final) | w_sup;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_adv_q   <= 1'b0;
      w_err_q   <= 1'b0;
      w_oor_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (s_axi_gmem_awvalid && awready_q) begin
            w_addr_q  <= s_axi_gmem_awaddr[AW+OFF_W-1:OFF_W];
            w_len_q   <= s_axi_gmem_awlen;
            w_adv_q   <= burst_advances(s_axi_gmem_awburst);
            w_oor_q   <= |s_axi_gmem_awaddr[48:AW+OFF_W];
            bid_q     <= s_axi_gmem_awid;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            if (w_adv_q) w_addr_q <= w_addr_q + 1'b1;
            w_err_q <= w_err_d;
            // The beat count, not wlast, ends the burst.
            if (w_final) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= w_err_d ? RESP_SLVERR : RESP_OKAY;
              w_state_q <= W_RESP;
            end else begin
              w_cnt_q <= w_cnt_q + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_gmem_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign r_beat = rvalid_q && s_axi_gmem_rready;
  assign r_sup  = RANGE_CHK & r_oor_q;
  // r_addr_q already points at the next word, so a fetch on each accepted beat keeps beats back-to-back.
  assign ram_re = (r_state_q == R_FETCH) || (r_beat && !rlast_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_adv_q   <= 1'b0;
      r_oor_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (s_axi_gmem_arvalid && arready_q) begin
            r_addr_q  <= s_axi_gmem_araddr[AW+OFF_W-1:OFF_W];
            r_len_q   <= s_axi_gmem_arlen;
            r_adv_q   <= burst_advances(s_axi_gmem_arburst);
            r_oor_q   <= |s_axi_gmem_araddr[48:AW+OFF_W];
            rid_q     <= s_axi_gmem_arid;
            arready_q <= 1'b0;
            r_state_q <= R_FETCH;
          end
        end
        R_FETCH: begin
          rvalid_q  <= 1'b1;
          rlast_q   <= (r_len_q == 8'd0);
          rresp_q   <= r_sup ? RESP_SLVERR : RESP_OKAY;
          r_cnt_q   <= '0;
          if (r_adv_q) r_addr_q <= r_addr_q + 1'b1;
          r_state_q <= R_DATA;
        end
        R_DATA: begin
          if (r_beat) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              r_cnt_q <= r_cnt_q + 8'd1;
              rlast_q <= ((r_cnt_q + 8'd1) == r_len_q);
              if (r_adv_q) r_addr_q <= r_addr_q + 1'b1;
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  rm_gmem_rsp_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .we_i    (w_beat && !w_sup),
    .waddr_i (w_addr_q),
    .wdata_i (s_axi_gmem_wdata),
    .wbe_i   (s_axi_gmem_wstrb),
    .re_i    (ram_re),
    .raddr_i (r_addr_q),
    .rdata_o (ram_rdata)
  );

  assign s_axi_gmem_awready = awready_q;
  assign s_axi_gmem_wready  = wready_q;
  assign s_axi_gmem_bvalid  = bvalid_q;
  assign s_axi_gmem_bresp   = bresp_q;
  assign s_axi_gmem_bid     = bid_q;
  assign s_axi_gmem_arready = arready_q;
  assign s_axi_gmem_rvalid  = rvalid_q;
  assign s_axi_gmem_rdata   = r_sup ? '0 : ram_rdata;
  assign s_axi_gmem_rlast   = rlast_q;
  assign s_axi_gmem_rid     = rid_q;
  assign s_axi_gmem_rresp   = rresp_q;
  assign dbg_w_state_o      = w_state_q;
  assign dbg_r_state_o      = r_state_q;

  logic unused_fields;
  assign unused_fields = ^{s_axi_gmem_awaddr[OFF_W-1:0], s_axi_gmem_awsize, s_axi_gmem_awlock,
                           s_axi_gmem_awcache, s_axi_gmem_awprot, s_axi_gmem_awqos,
                           s_axi_gmem_awregion, s_axi_gmem_araddr[OFF_W-1:0], s_axi_gmem_arsize,
                           s_axi_gmem_arlock, s_axi_gmem_arcache, s_axi_gmem_arprot,
                           s_axi_gmem_arqos, s_axi_gmem_arregion};

endmodule
